// File: rtl/fpga_robots_game_ps2_rx.sv
// Receive-only PS/2 keyboard front end: synchronises and de-glitches the PS/2 pins,
// deframes 11-bit device-to-host frames and emits good bytes as one-cycle strobes.
module fpga_robots_game_ps2_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic [7:0] rx_dat,
  output logic       rx_stb,
  output logic       rx_err,
  output logic       dbg
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  function automatic logic [FW-1:0] flt_inc(input logic [FW-1:0] c);
    return (c == FW'(FILTER_LEN)) ? c : c + 1'b1;
  endfunction

  function automatic logic [TW-1:0] to_inc(input logic [TW-1:0] c);
    return (c == TW'(TIMEOUT_CYC)) ? c : c + 1'b1;
  endfunction

  logic          ps2_clk_p0, ps2_clk_p1;
  logic          ps2_dat_p0, ps2_dat_p1;
  logic          fclk, fclk_d1, fall;
  logic [FW-1:0] flt_cnt, flt_cnt_inc;
  logic [TW-1:0] to_cnt;
  logic          to_hit;

  state_t        state, state_nxt;
  logic [2:0]    bitcnt, bitcnt_nxt;
  logic [7:0]    sh, sh_nxt;
  logic          par, par_nxt;
  logic [7:0]    dat_nxt;
  logic          stb_nxt, err_nxt;

  // Stage p0/p1: two-flop synchronisers on both pins
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2_clk_p0 <= 1'b1;
      ps2_clk_p1 <= 1'b1;
      ps2_dat_p0 <= 1'b1;
      ps2_dat_p1 <= 1'b1;
    end else begin
      ps2_clk_p0 <= ps2_clk_in;
      ps2_clk_p1 <= ps2_clk_p0;
      ps2_dat_p0 <= ps2_dat_in;
      ps2_dat_p1 <= ps2_dat_p0;
    end
  end

  // Filtered clock follows the synced clock only after it differs for FILTER_LEN cycles
  assign flt_cnt_inc = flt_inc(flt_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      fclk    <= 1'b1;
      fclk_d1 <= 1'b1;
      flt_cnt <= '0;
    end else begin
      fclk_d1 <= fclk;
      if (ps2_clk_p1 == fclk) begin
        flt_cnt <= '0;
      end else if (flt_cnt_inc == FW'(FILTER_LEN)) begin
        fclk    <= ps2_clk_p1;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt_inc;
      end
    end
  end

  assign fall = fclk_d1 & ~fclk;

  // A falling edge in the same cycle as expiry keeps the frame alive
  assign to_hit = (to_cnt == TW'(TIMEOUT_CYC)) && !fall && (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (fall || (state == IDLE) || to_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_inc(to_cnt);
    end
  end

  always_comb begin
    state_nxt  = state;
    bitcnt_nxt = bitcnt;
    sh_nxt     = sh;
    par_nxt    = par;
    dat_nxt    = rx_dat;
    stb_nxt    = 1'b0;
    err_nxt    = 1'b0;
    if (to_hit) begin
      state_nxt = IDLE;
      err_nxt   = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!ps2_dat_p1) begin
            state_nxt  = DATA;
            bitcnt_nxt = 3'd0;
          end
        end
        DATA: begin
          sh_nxt     = {ps2_dat_p1, sh[7:1]};
          bitcnt_nxt = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_nxt = PAR;
        end
        PAR: begin
          par_nxt   = ps2_dat_p1;
          state_nxt = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          if (ps2_dat_p1 && (^{sh, par})) begin
            dat_nxt = sh;
            stb_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage out: control and result registers; strobes land one cycle after the stop-bit fall
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      bitcnt <= 3'd0;
      rx_dat <= 8'h00;
      rx_stb <= 1'b0;
      rx_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      bitcnt <= bitcnt_nxt;
      rx_dat <= dat_nxt;
      rx_stb <= stb_nxt;
      rx_err <= err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    sh  <= sh_nxt;
    par <= par_nxt;
  end

  assign dbg = (state != IDLE);

endmodule
